// File: rtl/frogger_game_fsm.sv
// rtl/frogger_game_fsm.sv - game-flow controller for frogger: lives, score, win/lose sequencing
//
// Purpose: tracks the game phase (IDLE/RUNNING/P1_WINS/CLEANUP), lives and score,
// and asks the Frogger controller to respawn after a hit or a goal.
// Ports:
//   i_Clk          system clock
//   i_Rst_n        synchronous active-low reset
//   i_Game_Start   debounced start button (level)
//   i_Collided     Frogger/car overlap flag
//   i_Frogger_Y    Frogger tile row
//   i_Bitmap_Data  tile code under Frogger (4 = lily pad)
//   o_State        00 IDLE, 01 RUNNING, 10 P1_WINS, 11 CLEANUP
//   o_Game_Active  high only while RUNNING
//   o_Lives        remaining lives
//   o_Score        goals reached, 0..99
//   o_Respawn      one-cycle pulse: return Frogger to start tile
//   o_Win          one-cycle pulse on entry to P1_WINS
module frogger_game_fsm #(
  parameter int c_INIT_LIVES     = 3,
  parameter int c_WIN_SCORE      = 5,
  parameter int c_GOAL_ROW       = 0,
  parameter int c_HIT_GUARD      = 2500000,
  parameter int c_CLEANUP_CYCLES = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Game_Start,
  input  logic       i_Collided,
  input  logic [5:0] i_Frogger_Y,
  input  logic [3:0] i_Bitmap_Data,
  output logic [1:0] o_State,
  output logic       o_Game_Active,
  output logic [1:0] o_Lives,
  output logic [6:0] o_Score,
  output logic       o_Respawn,
  output logic       o_Win
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    P1_WINS = 2'b10,
    CLEANUP = 2'b11
  } state_t;

  localparam int GW = $clog2(c_HIT_GUARD + 1);
  localparam int CW = $clog2(c_CLEANUP_CYCLES + 1);

  localparam logic [GW-1:0] GUARD_LOAD   = GW'(c_HIT_GUARD);
  localparam logic [GW-1:0] GUARD_ONE    = GW'(1);
  localparam logic [GW-1:0] GUARD_ZERO   = '0;
  localparam logic [CW-1:0] CLEANUP_LAST = CW'(c_CLEANUP_CYCLES - 1);
  localparam logic [CW-1:0] TIMER_ONE    = CW'(1);
  localparam logic [1:0]    INIT_LIVES   = 2'(c_INIT_LIVES);
  localparam logic [6:0]    WIN_SCORE    = 7'(c_WIN_SCORE);
  localparam logic [6:0]    MAX_SCORE    = 7'd99;
  localparam logic [5:0]    GOAL_ROW     = 6'(c_GOAL_ROW);
  localparam logic [3:0]    LILY_PAD     = 4'd4;

  state_t        state, state_nx;
  logic [GW-1:0] guard, guard_nx;
  logic [CW-1:0] timer, timer_nx;
  logic [1:0]    lives, lives_nx;
  logic [6:0]    score, score_nx;
  logic          respawn, respawn_nx;
  logic          win, win_nx;
  logic          active;

  // Previous samples for edge detection. prev_start resets high so a button
  // held down through reset cannot start a game on release.
  logic prev_start, prev_collided, prev_pad, prev_wall;

  logic       at_goal_row, on_pad, on_wall;
  logic       start_edge, hit_ev, goal_ev;
  logic [6:0] score_inc;

  assign at_goal_row = (i_Frogger_Y == GOAL_ROW);
  assign on_pad      = at_goal_row && (i_Bitmap_Data == LILY_PAD);
  assign on_wall     = at_goal_row && (i_Bitmap_Data != LILY_PAD);
  assign start_edge  = i_Game_Start && !prev_start;
  assign hit_ev      = (i_Collided && !prev_collided) || (on_wall && !prev_wall);
  assign goal_ev     = on_pad && !prev_pad;
  assign score_inc   = (score >= MAX_SCORE) ? MAX_SCORE : score + 7'd1;

  always_comb begin
    state_nx   = state;
    guard_nx   = (guard != GUARD_ZERO) ? guard - GUARD_ONE : guard;
    timer_nx   = timer;
    lives_nx   = lives;
    score_nx   = score;
    respawn_nx = 1'b0;
    win_nx     = 1'b0;

    case (state)
      IDLE: begin
        lives_nx = INIT_LIVES;
        score_nx = '0;
        if (start_edge) begin
          state_nx   = RUNNING;
          respawn_nx = 1'b1;
        end
      end

      RUNNING: begin
        // Events landing inside the guard window are dropped; a hit takes
        // priority over a goal seen in the same cycle.
        if (guard == GUARD_ZERO) begin
          if (hit_ev) begin
            guard_nx = GUARD_LOAD;
            if (lives <= 2'd1) begin
              lives_nx = 2'd0;
              state_nx = CLEANUP;
            end else begin
              lives_nx   = lives - 2'd1;
              respawn_nx = 1'b1;
            end
          end else if (goal_ev) begin
            guard_nx = GUARD_LOAD;
            score_nx = score_inc;
            if (score_inc >= WIN_SCORE) begin
              state_nx = P1_WINS;
              win_nx   = 1'b1;
            end else begin
              respawn_nx = 1'b1;
            end
          end
        end
      end

      P1_WINS: begin
        if (start_edge) state_nx = CLEANUP;
      end

      CLEANUP: begin
        if (timer == CLEANUP_LAST) begin
          timer_nx = '0;
          score_nx = '0;
          lives_nx = INIT_LIVES;
          state_nx = IDLE;
        end else begin
          timer_nx = timer + TIMER_ONE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state         <= IDLE;
      guard         <= '0;
      timer         <= '0;
      lives         <= INIT_LIVES;
      score         <= '0;
      respawn       <= 1'b0;
      win           <= 1'b0;
      active        <= 1'b0;
      prev_start    <= 1'b1;
      prev_collided <= 1'b0;
      prev_pad      <= 1'b0;
      prev_wall     <= 1'b0;
    end else begin
      state         <= state_nx;
      guard         <= guard_nx;
      timer         <= timer_nx;
      lives         <= lives_nx;
      score         <= score_nx;
      respawn       <= respawn_nx;
      win           <= win_nx;
      active        <= (state_nx == RUNNING);
      prev_start    <= i_Game_Start;
      prev_collided <= i_Collided;
      prev_pad      <= on_pad;
      prev_wall     <= on_wall;
    end
  end

  assign o_State       = state;
  assign o_Game_Active = active;
  assign o_Lives       = lives;
  assign o_Score       = score;
  assign o_Respawn     = respawn;
  assign o_Win         = win;

endmodule

// File: tb/tb_frogger_game_fsm.sv
// tb/tb_frogger_game_fsm.sv - directed and random checks of frogger_game_fsm against a rule-level model
module tb_frogger_game_fsm;

  localparam int INIT_LIVES = 3;
  localparam int WIN_SCORE  = 2;
  localparam int GOAL_ROW   = 0;
  localparam int HIT_GUARD  = 4;
  localparam int CLEAN_CYC  = 8;

  localparam int M_IDLE = 0, M_RUN = 1, M_WIN = 2, M_CLEAN = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_start = 1'b0;
  logic       collided = 1'b0;
  logic [5:0] frog_y = 6'd10;
  logic [3:0] bmp = 4'd0;
  logic [1:0] o_State;
  logic       o_Game_Active;
  logic [1:0] o_Lives;
  logic [6:0] o_Score;
  logic       o_Respawn;
  logic       o_Win;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: game phase, counters and edge memory as plain integers
  int m_mode, m_lives, m_score, m_resp, m_win;
  int m_edge, m_blocked_until, m_clean_left;
  bit m_ps, m_pc, m_pg, m_pw;

  frogger_game_fsm #(
    .c_INIT_LIVES(INIT_LIVES),
    .c_WIN_SCORE(WIN_SCORE),
    .c_GOAL_ROW(GOAL_ROW),
    .c_HIT_GUARD(HIT_GUARD),
    .c_CLEANUP_CYCLES(CLEAN_CYC)
  ) dut (
    .i_Clk(clk),
    .i_Rst_n(rst_n),
    .i_Game_Start(game_start),
    .i_Collided(collided),
    .i_Frogger_Y(frog_y),
    .i_Bitmap_Data(bmp),
    .o_State(o_State),
    .o_Game_Active(o_Game_Active),
    .o_Lives(o_Lives),
    .o_Score(o_Score),
    .o_Respawn(o_Respawn),
    .o_Win(o_Win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_lives = INIT_LIVES; m_score = 0; m_resp = 0; m_win = 0;
    m_blocked_until = m_edge; m_clean_left = 0;
    m_ps = 1'b1; m_pc = 1'b0; m_pg = 1'b0; m_pw = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit co, input int y, input int b, input bit rn);
    bit pad, wall, s_e, hit, goal, free;
    m_edge++;
    if (!rn) begin
      model_reset();
      return;
    end
    pad  = (y == GOAL_ROW) && (b == 4);
    wall = (y == GOAL_ROW) && (b != 4);
    s_e  = st && !m_ps;
    hit  = (co && !m_pc) || (wall && !m_pw);
    goal = pad && !m_pg;
    free = (m_edge > m_blocked_until);
    m_resp = 0;
    m_win  = 0;
    if (m_mode == M_IDLE) begin
      m_lives = INIT_LIVES;
      m_score = 0;
      if (s_e) begin m_mode = M_RUN; m_resp = 1; end
    end else if (m_mode == M_RUN) begin
      if (free && hit) begin
        m_blocked_until = m_edge + HIT_GUARD;
        if (m_lives <= 1) begin
          m_lives = 0; m_mode = M_CLEAN; m_clean_left = CLEAN_CYC;
        end else begin
          m_lives = m_lives - 1; m_resp = 1;
        end
      end else if (free && goal) begin
        m_blocked_until = m_edge + HIT_GUARD;
        m_score = (m_score >= 99) ? 99 : m_score + 1;
        if (m_score >= WIN_SCORE) begin m_mode = M_WIN; m_win = 1; end
        else m_resp = 1;
      end
    end else if (m_mode == M_WIN) begin
      if (s_e) begin m_mode = M_CLEAN; m_clean_left = CLEAN_CYC; end
    end else begin
      m_clean_left--;
      if (m_clean_left == 0) begin
        m_mode = M_IDLE; m_score = 0; m_lives = INIT_LIVES;
      end
    end
    m_ps = st; m_pc = co; m_pg = pad; m_pw = wall;
  endtask

  // drive inputs, clock once, advance the model, compare every output
  task automatic cyc(input bit st, input bit co, input int y, input int b, input bit rn);
    game_start = st; collided = co; frog_y = 6'(y); bmp = 4'(b); rst_n = rn;
    @(posedge clk);
    model_edge(st, co, y, b, rn);
    #1;
    chk("state",   int'(o_State),       m_mode);
    chk("active",  int'(o_Game_Active), (m_mode == M_RUN) ? 1 : 0);
    chk("lives",   int'(o_Lives),       m_lives);
    chk("score",   int'(o_Score),       m_score);
    chk("respawn", int'(o_Respawn),     m_resp);
    chk("win",     int'(o_Win),         m_win);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 10, 0, 1);
  endtask

  initial begin
    m_edge = 0;
    model_reset();

    // button held through reset must not start a game
    for (int i = 0; i < 3; i++) cyc(1, 0, 10, 0, 0);
    cyc(1, 0, 10, 0, 1);
    cyc(1, 0, 10, 0, 1);
    chk("held_start_state", int'(o_State), 0);
    chk("reset_lives", int'(o_Lives), 3);
    cyc(0, 0, 10, 0, 1);
    cyc(1, 0, 10, 0, 1);
    chk("start_state", int'(o_State), 1);
    chk("start_respawn", int'(o_Respawn), 1);
    idle(1);
    chk("respawn_single", int'(o_Respawn), 0);

    // two hits two cycles apart: second falls inside the guard
    idle(2);
    cyc(0, 1, 10, 0, 1);
    chk("hit1_lives", int'(o_Lives), 2);
    cyc(0, 0, 10, 0, 1);
    cyc(0, 1, 10, 0, 1);
    chk("guarded_hit_lives", int'(o_Lives), 2);
    chk("guarded_hit_resp", int'(o_Respawn), 0);

    // run out of lives, then the cleanup delay
    idle(6);
    cyc(0, 1, 10, 0, 1);
    idle(6);
    cyc(0, 1, 10, 0, 1);
    chk("last_hit_state", int'(o_State), 3);
    chk("last_hit_lives", int'(o_Lives), 0);
    chk("last_hit_noresp", int'(o_Respawn), 0);
    idle(7);
    chk("cleanup_hold", int'(o_State), 3);
    idle(1);
    chk("cleanup_done_state", int'(o_State), 0);
    chk("cleanup_done_lives", int'(o_Lives), 3);

    // two goals win the game
    cyc(1, 0, 10, 0, 1);
    idle(1);
    cyc(0, 0, 0, 4, 1);
    chk("goal1_score", int'(o_Score), 1);
    chk("goal1_resp", int'(o_Respawn), 1);
    idle(5);
    cyc(0, 0, 0, 4, 1);
    chk("goal2_state", int'(o_State), 2);
    chk("goal2_win", int'(o_Win), 1);
    chk("goal2_noresp", int'(o_Respawn), 0);
    idle(1);
    chk("win_single", int'(o_Win), 0);
    cyc(1, 0, 10, 0, 1);
    chk("win_to_cleanup", int'(o_State), 3);
    idle(8);
    chk("win_cleanup_idle", int'(o_State), 0);

    // wall hit, then hit and goal together
    cyc(1, 0, 10, 0, 1);
    idle(1);
    cyc(0, 0, 0, 0, 1);
    chk("wall_lives", int'(o_Lives), 2);
    chk("wall_score", int'(o_Score), 0);
    idle(5);
    cyc(0, 1, 0, 4, 1);
    chk("hit_beats_goal_lives", int'(o_Lives), 1);
    chk("hit_beats_goal_score", int'(o_Score), 0);

    // reset in the middle of a game
    cyc(0, 0, 10, 0, 0);
    cyc(0, 0, 10, 0, 1);
    cyc(1, 0, 10, 0, 1);
    idle(1);
    cyc(0, 0, 0, 4, 1);
    idle(5);
    cyc(0, 1, 10, 0, 1);
    chk("pre_reset_score", int'(o_Score), 1);
    chk("pre_reset_lives", int'(o_Lives), 2);
    idle(1);
    cyc(0, 0, 10, 0, 0);
    chk("midreset_state", int'(o_State), 0);
    chk("midreset_score", int'(o_Score), 0);
    chk("midreset_lives", int'(o_Lives), 3);
    chk("midreset_resp", int'(o_Respawn), 0);

    // random play
    for (int i = 0; i < 3000; i++) begin
      int y, b;
      bit st, co, rn;
      st = ($urandom_range(0, 9) < 3);
      co = ($urandom_range(0, 7) == 0);
      y  = int'($urandom_range(0, 3));
      b  = ($urandom_range(0, 1) == 0) ? 4 : int'($urandom_range(0, 7));
      rn = ($urandom_range(0, 199) != 0);
      cyc(st, co, y, b, rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
